// File: rtl/spi_slave_rx_fifo.sv
// Receive FIFO and reply register sitting downstream of the 16-bit SPI slave.
// Optional: define SPI_RX_FIFO_DROP_OLDEST_EN to evict the oldest word on overflow.
module spi_slave_rx_fifo #(
  parameter  int DEPTH = 8,
  parameter  int WIDTH = 16,
  localparam int PW    = $clog2(DEPTH),
  localparam int LW    = PW + 1
) (
  input  logic             clk_i,
  input  logic             reset_n,
  input  logic             slv_wr_req,
  input  logic [WIDTH-1:0] slv_dat_i,
  output logic             slv_wr_req_ack,
  input  logic             slv_busy,
  output logic [WIDTH-1:0] slv_dat_o,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [LW-1:0]    level,
  output logic             overflow,
  input  logic             clr_i
);

  typedef enum logic [1:0] {
    IDLE,
    ACK,
    WAIT_LOW
  } cap_state_e;

  cap_state_e state_q, state_d;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic [LW-1:0]    level_d;
  logic             ovf_q;
  logic [WIDTH-1:0] reply_q;

  logic push_req;
  logic full;
  logic pop;
  logic push_ok;
  logic evict;
  logic lost;
  logic wr_en;
  logic rd_adv;

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // One capture per frame: WAIT_LOW blocks re-capture until the request drops.
  always_comb begin
    state_d  = state_q;
    push_req = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (slv_wr_req) begin
          push_req = 1'b1;
          state_d  = ACK;
        end
      end
      ACK:      state_d = WAIT_LOW;
      WAIT_LOW: if (!slv_wr_req) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  assign slv_wr_req_ack = (state_q == ACK);

  assign full     = (level_q == LW'(DEPTH));
  assign rx_valid = (level_q != '0);
  assign pop      = rx_valid & rx_ready;
  assign push_ok  = push_req & (~full | pop);

`ifdef SPI_RX_FIFO_DROP_OLDEST_EN
  assign evict = push_req & full & ~pop;
  assign lost  = evict;
`else
  assign evict = 1'b0;
  assign lost  = push_req & full & ~pop;
`endif

  // An eviction overwrites the slot the read pointer is leaving.
  assign wr_en  = push_ok | evict;
  assign rd_adv = pop | evict;

  always_comb begin
    level_d = level_q;
    unique case (1'b1)
      push_ok & ~pop: level_d = level_q + LW'(1);
      pop & ~push_ok: level_d = level_q - LW'(1);
      default:        level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (wr_en)  wr_ptr_q <= wr_ptr_q + PW'(1);
      if (rd_adv) rd_ptr_q <= rd_ptr_q + PW'(1);
      level_q <= level_d;
      ovf_q   <= ovf_q | lost;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en && !clr_i) mem[wr_ptr_q] <= slv_dat_i;
  end

  assign rx_data  = mem[rd_ptr_q];
  assign level    = level_q;
  assign overflow = ovf_q;

  assign tx_ready = ~slv_busy;

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n)                 reply_q <= '0;
    else if (tx_valid & tx_ready) reply_q <= tx_data;
  end

  assign slv_dat_o = reply_q;

endmodule

// File: tb/tb_spi_slave_rx_fifo.sv
// Directed bench for spi_slave_rx_fifo: vector table plus hand sequences.
// Honours SPI_RX_FIFO_DROP_OLDEST_EN for the overflow ordering check.
module tb_spi_slave_rx_fifo;

  logic        clk_i = 1'b0;
  logic        reset_n;
  logic        slv_wr_req;
  logic [15:0] slv_dat_i;
  logic        slv_wr_req_ack;
  logic        slv_busy;
  logic [15:0] slv_dat_o;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [15:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [3:0]  level;
  logic        overflow;
  logic        clr_i;

  int n_chk  = 0;
  int n_fail = 0;

  spi_slave_rx_fifo #(.DEPTH(8), .WIDTH(16)) dut (
    .clk_i          (clk_i),
    .reset_n        (reset_n),
    .slv_wr_req     (slv_wr_req),
    .slv_dat_i      (slv_dat_i),
    .slv_wr_req_ack (slv_wr_req_ack),
    .slv_busy       (slv_busy),
    .slv_dat_o      (slv_dat_o),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_ready       (rx_ready),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .level          (level),
    .overflow       (overflow),
    .clr_i          (clr_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        req;
    logic [15:0] din;
    logic        rdy;
    logic        busy;
    logic        txv;
    logic [15:0] txd;
    logic        e_ack;
    logic        e_vld;
    logic [15:0] e_dat;
    logic [3:0]  e_lvl;
    logic        e_ovf;
    logic [15:0] e_dout;
    logic        e_trdy;
  } vec_t;

  vec_t tbl [14];

  function automatic vec_t mk(
    logic req, logic [15:0] din, logic rdy, logic busy,
    logic txv, logic [15:0] txd, logic e_ack, logic e_vld,
    logic [15:0] e_dat, logic [3:0] e_lvl, logic e_ovf,
    logic [15:0] e_dout, logic e_trdy);
    vec_t v;
    v.req = req; v.din = din; v.rdy = rdy; v.busy = busy;
    v.txv = txv; v.txd = txd; v.e_ack = e_ack; v.e_vld = e_vld;
    v.e_dat = e_dat; v.e_lvl = e_lvl; v.e_ovf = e_ovf;
    v.e_dout = e_dout; v.e_trdy = e_trdy;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_word(logic [15:0] w);
    slv_wr_req = 1'b1;
    slv_dat_i  = w;
    step();
    chk("push_ack", 32'(slv_wr_req_ack), 32'd1);
    slv_wr_req = 1'b0;
    step();
    step();
  endtask

  task automatic pop_check(string name, logic [15:0] w);
    chk({name, "_valid"}, 32'(rx_valid), 32'd1);
    chk({name, "_data"}, 32'(rx_data), 32'(w));
    rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks;
    logic [15:0] exp_w;

    //        req din      rdy bsy txv txd      ack vld dat      lvl ovf dout     trdy
    tbl[0]  = mk(1, 16'hA55A, 0, 0, 0, 16'h0000, 1, 1, 16'hA55A, 1, 0, 16'h0000, 1);
    tbl[1]  = mk(1, 16'hA55A, 0, 0, 0, 16'h0000, 0, 1, 16'hA55A, 1, 0, 16'h0000, 1);
    tbl[2]  = mk(0, 16'h0000, 1, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 1);
    tbl[3]  = mk(0, 16'h0000, 0, 1, 1, 16'h1234, 0, 0, 16'h0000, 0, 0, 16'h0000, 0);
    tbl[4]  = mk(0, 16'h0000, 0, 0, 1, 16'h1234, 0, 0, 16'h0000, 0, 0, 16'h1234, 1);
    tbl[5]  = mk(0, 16'h0000, 0, 1, 1, 16'hBEEF, 0, 0, 16'h0000, 0, 0, 16'h1234, 0);
    tbl[6]  = mk(0, 16'h0000, 0, 0, 0, 16'hBEEF, 0, 0, 16'h0000, 0, 0, 16'h1234, 1);
    tbl[7]  = mk(1, 16'h0001, 0, 0, 0, 16'h0000, 1, 1, 16'h0001, 1, 0, 16'h1234, 1);
    tbl[8]  = mk(0, 16'h0000, 0, 0, 0, 16'h0000, 0, 1, 16'h0001, 1, 0, 16'h1234, 1);
    tbl[9]  = mk(1, 16'h0002, 0, 0, 0, 16'h0000, 0, 1, 16'h0001, 1, 0, 16'h1234, 1);
    tbl[10] = mk(0, 16'h0000, 0, 0, 0, 16'h0000, 0, 1, 16'h0001, 1, 0, 16'h1234, 1);
    tbl[11] = mk(1, 16'h0002, 0, 0, 0, 16'h0000, 1, 1, 16'h0001, 2, 0, 16'h1234, 1);
    tbl[12] = mk(0, 16'h0000, 1, 0, 0, 16'h0000, 0, 1, 16'h0002, 1, 0, 16'h1234, 1);
    tbl[13] = mk(0, 16'h0000, 1, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h1234, 1);

    reset_n    = 1'b0;
    slv_wr_req = 1'b0;
    slv_dat_i  = '0;
    slv_busy   = 1'b0;
    rx_ready   = 1'b0;
    tx_data    = '0;
    tx_valid   = 1'b0;
    clr_i      = 1'b0;
    step();
    step();
    chk("rst_ack", 32'(slv_wr_req_ack), 32'd0);
    chk("rst_valid", 32'(rx_valid), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_dout", 32'(slv_dat_o), 32'd0);
    @(negedge clk_i);
    reset_n = 1'b1;
    step();

    for (int i = 0; i < 14; i++) begin
      slv_wr_req = tbl[i].req;
      slv_dat_i  = tbl[i].din;
      rx_ready   = tbl[i].rdy;
      slv_busy   = tbl[i].busy;
      tx_valid   = tbl[i].txv;
      tx_data    = tbl[i].txd;
      step();
      chk($sformatf("v%0d_ack", i), 32'(slv_wr_req_ack), 32'(tbl[i].e_ack));
      chk($sformatf("v%0d_valid", i), 32'(rx_valid), 32'(tbl[i].e_vld));
      if (tbl[i].e_vld)
        chk($sformatf("v%0d_data", i), 32'(rx_data), 32'(tbl[i].e_dat));
      chk($sformatf("v%0d_level", i), 32'(level), 32'(tbl[i].e_lvl));
      chk($sformatf("v%0d_ovf", i), 32'(overflow), 32'(tbl[i].e_ovf));
      chk($sformatf("v%0d_dout", i), 32'(slv_dat_o), 32'(tbl[i].e_dout));
      chk($sformatf("v%0d_trdy", i), 32'(tx_ready), 32'(tbl[i].e_trdy));
    end
    slv_wr_req = 1'b0;
    rx_ready   = 1'b0;
    slv_busy   = 1'b0;
    tx_valid   = 1'b0;
    step();

    for (int i = 1; i <= 9; i++) push_word(16'(i));
    chk("ovf_level", 32'(level), 32'd8);
    chk("ovf_flag", 32'(overflow), 32'd1);
    for (int i = 0; i < 8; i++) begin
`ifdef SPI_RX_FIFO_DROP_OLDEST_EN
      exp_w = 16'(i + 2);
`else
      exp_w = 16'(i + 1);
`endif
      pop_check($sformatf("ovf_pop%0d", i), exp_w);
    end
    chk("ovf_empty", 32'(rx_valid), 32'd0);

    for (int i = 0; i < 3; i++) push_word(16'h0100 + 16'(i));
    chk("clr_pre_level", 32'(level), 32'd3);
    chk("clr_pre_ovf", 32'(overflow), 32'd1);
    clr_i = 1'b1;
    step();
    clr_i = 1'b0;
    chk("clr_level", 32'(level), 32'd0);
    chk("clr_valid", 32'(rx_valid), 32'd0);
    chk("clr_ovf", 32'(overflow), 32'd0);

    for (int i = 0; i < 8; i++) push_word(16'h0010 + 16'(i));
    chk("full_level", 32'(level), 32'd8);
    slv_wr_req = 1'b1;
    slv_dat_i  = 16'h0099;
    rx_ready   = 1'b1;
    step();
    rx_ready   = 1'b0;
    slv_wr_req = 1'b0;
    chk("pp_ack", 32'(slv_wr_req_ack), 32'd1);
    chk("pp_level", 32'(level), 32'd8);
    chk("pp_ovf", 32'(overflow), 32'd0);
    step();
    step();
    for (int i = 1; i < 8; i++)
      pop_check($sformatf("pp_pop%0d", i), 16'h0010 + 16'(i));
    pop_check("pp_pop_new", 16'h0099);
    chk("pp_empty", 32'(level), 32'd0);

    acks = 0;
    slv_wr_req = 1'b1;
    slv_dat_i  = 16'h0055;
    for (int i = 0; i < 5; i++) begin
      step();
      if (slv_wr_req_ack) acks++;
    end
    slv_wr_req = 1'b0;
    step();
    if (slv_wr_req_ack) acks++;
    step();
    chk("hold_acks", 32'(acks), 32'd1);
    chk("hold_level", 32'(level), 32'd1);
    pop_check("hold_pop", 16'h0055);

    slv_wr_req = 1'b1;
    slv_dat_i  = 16'h0077;
    clr_i      = 1'b1;
    step();
    clr_i      = 1'b0;
    slv_wr_req = 1'b0;
    chk("clrpush_ack", 32'(slv_wr_req_ack), 32'd1);
    chk("clrpush_level", 32'(level), 32'd0);
    chk("clrpush_ovf", 32'(overflow), 32'd0);
    step();
    step();

    slv_wr_req = 1'b1;
    slv_dat_i  = 16'hCAFE;
    step();
    chk("mid_ack", 32'(slv_wr_req_ack), 32'd1);
    chk("mid_level", 32'(level), 32'd1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("arst_ack", 32'(slv_wr_req_ack), 32'd0);
    chk("arst_valid", 32'(rx_valid), 32'd0);
    chk("arst_level", 32'(level), 32'd0);
    chk("arst_ovf", 32'(overflow), 32'd0);
    chk("arst_dout", 32'(slv_dat_o), 32'd0);
    @(negedge clk_i);
    reset_n = 1'b1;
    step();
    chk("post_ack", 32'(slv_wr_req_ack), 32'd1);
    chk("post_level", 32'(level), 32'd1);
    chk("post_data", 32'(rx_data), 32'hCAFE);
    slv_wr_req = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_slave_rx_fifo.md
# spi_slave_rx_fifo

Receive-side buffer placed directly downstream of the 16-bit SPI slave. Accepts each completed frame over the slave's `wr_req` / `wr_req_ack` host handshake and queues it in a DEPTH-word FIFO. Presents queued words to the system side as a valid/ready stream. Also holds the reply word the slave shifts out on MISO during the next frame.

## Interface
Parameters:
- `DEPTH`, 8, FIFO depth in words; power of two, ≥ 2
- `WIDTH`, 16, word width; must match the slave data width

Ports:
- `clk_i`  in  1  system clock; same clock as the slave's `clk_i`
- `reset_n`  in  1  asynchronous, active-low reset
- `slv_wr_req`  in  1  slave frame-complete request; level, held until acknowledged
- `slv_dat_i`  in  WIDTH  received word from the slave; stable while `slv_wr_req` is high
- `slv_wr_req_ack`  out  1  one-cycle acknowledge pulse to the slave
- `slv_busy`  in  1  slave chip-select active (frame in progress)
- `slv_dat_o`  out  WIDTH  reply word driven to the slave's MISO mux
- `rx_data`  out  WIDTH  head of FIFO (show-ahead)
- `rx_valid`  out  1  FIFO not empty
- `rx_ready`  in  1  consumer pops the head when `rx_valid & rx_ready`
- `tx_data`  in  WIDTH  next reply word
- `tx_valid`  in  1  reply word offered
- `tx_ready`  out  1  reply register may load; equals `~slv_busy`
- `level`  out  $clog2(DEPTH)+1  current word count, 0..DEPTH
- `overflow`  out  1  sticky flag: a word was lost or overwritten
- `clr_i`  in  1  synchronous flush of the FIFO and clear of `overflow`

## Operation
Capture FSM, 3 states:
- `IDLE`: when `slv_wr_req`=1, attempt a push of `slv_dat_i`, set `slv_wr_req_ack` for the next cycle, go to `ACK`.
- `ACK`: `slv_wr_req_ack`=1 for exactly this cycle; go to `WAIT_LOW`.
- `WAIT_LOW`: stay until `slv_wr_req`=0, then go to `IDLE`. This prevents a double capture of one frame.

Push and pop rules:
- A push is accepted when `level < DEPTH`, or when `level == DEPTH` and a pop occurs in the same cycle.
- A push that is not accepted drops the word and sets `overflow`. The slave is still acknowledged.
- Pop occurs on `rx_valid & rx_ready`. `rx_data` is undefined-but-stable when `rx_valid`=0.
- Simultaneous push and pop: `level` is unchanged and both pointers advance.
- Pointers are `$clog2(DEPTH)` bits wide and wrap modulo DEPTH. `level` is tracked separately.
- `clr_i`=1: pointers and `level` go to 0 and `overflow` goes to 0. `clr_i` wins over a same-cycle push or pop; the pushed word is discarded without setting `overflow`. Capture FSM state is unaffected, so the ack is still issued.

Reply register:
- Loads `tx_data` on `tx_valid & tx_ready`.
- Holds its value while `slv_busy`=1, so the word is never changed mid-frame.
- Holds its value indefinitely when no new word is offered; the last word is repeated.

## Timing
- Reset values: FSM `IDLE`; `slv_wr_req_ack` 0; `slv_dat_o` 0; `rx_valid` 0; `level` 0; `overflow` 0; pointers 0. `tx_ready` follows `~slv_busy` combinationally.
- Capture latency: `slv_wr_req` sampled high at edge N → `slv_wr_req_ack` high in cycle N+1 only. The word appears on `rx_data` with `rx_valid`=1 in cycle N+1 if the FIFO was empty.
- Minimum spacing between accepted frames: 3 cycles.
- Pop: `rx_valid & rx_ready` at edge M → next word (or `rx_valid`=0) in cycle M+1.
- Reply load: `tx_data` captured at edge K → `slv_dat_o` updated in cycle K+1.
- `reset_n` asserted mid-operation: all state clears immediately. A pending `slv_wr_req` is captured normally once reset deasserts.

## Configuration
- `SPI_RX_FIFO_DROP_OLDEST_EN` defined:
  - On a push to a full FIFO with no same-cycle pop, the oldest word is discarded (read pointer advances) and the new word is stored.
  - `level` stays at DEPTH and `overflow` is set.
- Not defined: the new word is dropped as described above.

## Test plan
- Single frame, `slv_dat_i`=16'hA55A → `slv_wr_req_ack` high one cycle; `rx_data`=16'hA55A, `rx_valid`=1, `level`=1; one pop → `level`=0, `rx_valid`=0.
- DEPTH=8, push 9 words 1..9 with `rx_ready`=0 → `overflow`=1, `level`=8.
  - Pops yield 1..8 without the macro.
  - Pops yield 2..9 with `SPI_RX_FIFO_DROP_OLDEST_EN`.
- FIFO full, push and pop in the same cycle → pushed word is accepted, `level` stays 8, `overflow` stays 0.
- `slv_wr_req` held high 5 cycles → exactly one push and one ack pulse.
- `tx_valid` with `tx_data`=16'h1234 while `slv_busy`=1 → `tx_ready`=0, `slv_dat_o` unchanged; `slv_busy` falls → `slv_dat_o`=16'h1234 one cycle after load.
- 3 words queued, `overflow`=1, assert `clr_i` → `level`=0, `rx_valid`=0, `overflow`=0; `reset_n` low mid-capture → `slv_wr_req_ack`=0 and all outputs at reset values immediately.
